// File: rtl/scorehand_accum.sv
// Running hand scorer: accepts one card per handshake, accumulates the score
// modulo MODULUS and tracks the hand fill state. Optional macro: SCOREHAND_NATURAL_EN.
//
// state     | meaning
// ----------+-------------------------------------------
// S_EMPTY   | no scoring card in hand (count == 0)
// S_PARTIAL | 0 < count < MAX_CARDS, cards still accepted
// S_FULL    | count == MAX_CARDS, holds until clear/reset
module scorehand_accum #(
   parameter int CARD_W    = 4,
   parameter int MAX_CARDS = 3,
   parameter int MODULUS   = 10,
   parameter int FACE_MIN  = 10,
   parameter int SCORE_W   = 4,
   parameter int CNT_W     = 2
) (
   input  logic               slow_clock,
   input  logic               resetb,
   input  logic               clear,
   input  logic               card_valid,
   input  logic [CARD_W-1:0]  card,
   output logic               card_ready,
   output logic [SCORE_W-1:0] total,
   output logic [CNT_W-1:0]   count,
   output logic               hand_full,
   output logic               full_pulse
`ifdef SCOREHAND_NATURAL_EN
   ,
   output logic               natural
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_PARTIAL = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   localparam logic [CARD_W-1:0]  FACE_C = CARD_W'(FACE_MIN);
   localparam logic [SCORE_W:0]   MOD_C  = (SCORE_W+1)'(MODULUS);
   localparam logic [CNT_W-1:0]   MAX_C  = CNT_W'(MAX_CARDS);

   state_t             state_q;
   logic [SCORE_W-1:0] total_q;
   logic [SCORE_W-1:0] total_d;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               full_pulse_q;
   logic [SCORE_W:0]   val;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W:0]   wrapped;
   logic               accept;
   logic               add_card;

   // val < MODULUS always holds, so one conditional subtract wraps the sum.
   always_comb begin
      val = '0;
      if (card < FACE_C) begin
         val = (SCORE_W+1)'(card);
      end
      sum     = {1'b0, total_q} + val;
      wrapped = (sum >= MOD_C) ? (sum - MOD_C) : sum;
      total_d = wrapped[SCORE_W-1:0];
      count_d = count_q + CNT_W'(1);
   end

   assign card_ready = (state_q != S_FULL) && !clear;
   assign accept     = card_valid && card_ready;
   assign add_card   = accept && (card != '0);

`ifdef SCOREHAND_NATURAL_EN
   localparam logic [SCORE_W:0] NAT_C = (SCORE_W+1)'(MODULUS - 2);
   logic natural_q;

   always_ff @(posedge slow_clock) begin
      if (!resetb || clear) begin
         natural_q <= 1'b0;
      end else if (add_card) begin
         natural_q <= (count_d == CNT_W'(2)) && (wrapped >= NAT_C);
      end
   end

   assign natural = natural_q;
`endif

   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state_q      <= S_EMPTY;
         total_q      <= '0;
         count_q      <= '0;
         full_pulse_q <= 1'b0;
      end else if (clear) begin
         state_q      <= S_EMPTY;
         total_q      <= '0;
         count_q      <= '0;
         full_pulse_q <= 1'b0;
      end else begin
         full_pulse_q <= 1'b0;
         if (add_card) begin
            total_q <= total_d;
            count_q <= count_d;
            if (count_d == MAX_C) begin
               state_q      <= S_FULL;
               full_pulse_q <= 1'b1;
            end else begin
               state_q <= S_PARTIAL;
            end
         end
      end
   end

   assign total      = total_q;
   assign count      = count_q;
   assign hand_full  = (state_q == S_FULL);
   assign full_pulse = full_pulse_q;

endmodule

// File: tb/tb_scorehand_accum.sv
// Bench for scorehand_accum: directed hand scenarios plus randomized traffic
// against a hand model that keeps the plain integer card sum.
module tb_scorehand_accum;

   localparam int CARD_W    = 4;
   localparam int MAX_CARDS = 3;
   localparam int MODULUS   = 10;
   localparam int FACE_MIN  = 10;
   localparam int SCORE_W   = 4;
   localparam int CNT_W     = 2;

   logic               slow_clock = 1'b0;
   logic               resetb;
   logic               clear;
   logic               card_valid;
   logic [CARD_W-1:0]  card;
   logic               card_ready;
   logic [SCORE_W-1:0] total;
   logic [CNT_W-1:0]   count;
   logic               hand_full;
   logic               full_pulse;
`ifdef SCOREHAND_NATURAL_EN
   logic               natural;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // hand model: number of scoring cards and plain (unwrapped) sum of values
   int m_cnt   = 0;
   int m_sum   = 0;
   bit m_pulse = 0;

   scorehand_accum #(
      .CARD_W(CARD_W), .MAX_CARDS(MAX_CARDS), .MODULUS(MODULUS),
      .FACE_MIN(FACE_MIN), .SCORE_W(SCORE_W), .CNT_W(CNT_W)
   ) dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .clear      (clear),
      .card_valid (card_valid),
      .card       (card),
      .card_ready (card_ready),
      .total      (total),
      .count      (count),
      .hand_full  (hand_full),
      .full_pulse (full_pulse)
`ifdef SCOREHAND_NATURAL_EN
      ,
      .natural    (natural)
`endif
   );

   always #5 slow_clock = ~slow_clock;

   function automatic int exp_total();
      return m_sum % MODULUS;
   endfunction

   function automatic bit exp_ready();
      return (m_cnt != MAX_CARDS) && !clear;
   endfunction

   task automatic drive(input logic v, input logic [CARD_W-1:0] c,
                        input logic clr, input logic rb);
      card_valid = v;
      card       = c;
      clear      = clr;
      resetb     = rb;
   endtask

   // one clock edge; the model consumes the inputs as they stood at the edge
   task automatic tick();
      bit rdy;
      bit v;
      int c;
      bit clr;
      bit rb;
      rdy = exp_ready();
      v   = card_valid;
      c   = int'(card);
      clr = clear;
      rb  = resetb;
      @(posedge slow_clock);
      if (!rb || clr) begin
         m_cnt   = 0;
         m_sum   = 0;
         m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (v && rdy && c != 0) begin
            m_cnt = m_cnt + 1;
            m_sum = m_sum + ((c >= FACE_MIN) ? 0 : c);
            m_pulse = (m_cnt == MAX_CARDS);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 4'd5, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (total !== 4'd0 || count !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: total=%0d count=%0d required 0 0", total, count);
      end
      n_checks++;
      if (hand_full !== 1'b0 || full_pulse !== 1'b0 || card_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_flags: full=%b pulse=%b ready=%b required 0 0 1",
                  hand_full, full_pulse, card_ready);
      end
   endtask

   task automatic test_sequence();
      logic [3:0] cards [3];
      int et [3];
      int ec [3];
      cards = '{4'd9, 4'd5, 4'd13};
      et = '{9, 4, 4};
      ec = '{1, 2, 3};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, cards[i], 1'b0, 1'b1);
         tick();
         n_checks++;
         if (int'(total) != et[i] || int'(count) != ec[i]) begin
            n_fail++;
            $display("FAIL seq_card%0d: total=%0d count=%0d required %0d %0d",
                     i, total, count, et[i], ec[i]);
         end
         n_checks++;
         if (full_pulse !== (i == 2) || hand_full !== (i == 2)) begin
            n_fail++;
            $display("FAIL seq_flags%0d: pulse=%b full=%b required %0b", i,
                     full_pulse, hand_full, (i == 2));
         end
      end
      n_checks++;
      if (card_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_ready_full: ready=%b required 0", card_ready);
      end
   endtask

   task automatic test_full_hold();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd7, 1'b0, 1'b1);
         tick();
         n_checks++;
         if (total !== 4'd4 || count !== 2'd3 || full_pulse !== 1'b0 || hand_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold%0d: total=%0d count=%0d pulse=%b full=%b required 4 3 0 1",
                     i, total, count, full_pulse, hand_full);
         end
      end
   endtask

   task automatic test_clear_priority();
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 4'd6, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (total !== 4'd6 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL clr_setup: total=%0d count=%0d required 6 1", total, count);
      end
      drive(1'b1, 4'd3, 1'b1, 1'b1);
      #1;
      n_checks++;
      if (card_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_ready: ready=%b required 0", card_ready);
      end
      tick();
      n_checks++;
      if (total !== 4'd0 || count !== 2'd0) begin
         n_fail++;
         $display("FAIL clr_priority: total=%0d count=%0d required 0 0", total, count);
      end
      drive(1'b1, 4'd3, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (total !== 4'd3 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL clr_after: total=%0d count=%0d required 3 1", total, count);
      end
   endtask

   task automatic test_zero_card();
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 4'd0, 1'b0, 1'b1);
         tick();
         n_checks++;
         if (total !== 4'd0 || count !== 2'd0 || hand_full !== 1'b0 || card_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_card%0d: total=%0d count=%0d full=%b ready=%b required 0 0 0 1",
                     i, total, count, hand_full, card_ready);
         end
      end
      drive(1'b1, 4'd12, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (total !== 4'd0 || count !== 2'd1) begin
         n_fail++;
         $display("FAIL face_card: total=%0d count=%0d required 0 1", total, count);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 4'd7, 1'b0, 1'b1);
      tick();
      drive(1'b1, 4'd8, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (total !== 4'd5 || count !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_setup: total=%0d count=%0d required 5 2", total, count);
      end
      drive(1'b1, 4'd2, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (total !== 4'd0 || count !== 2'd0 || full_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: total=%0d count=%0d pulse=%b required 0 0 0",
                  total, count, full_pulse);
      end
   endtask

`ifdef SCOREHAND_NATURAL_EN
   task automatic test_natural();
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 4'd4, 1'b0, 1'b1);
      tick();
      tick();
      n_checks++;
      if (natural !== 1'b1 || total !== 4'd8 || count !== 2'd2) begin
         n_fail++;
         $display("FAIL natural_set: nat=%b total=%0d count=%0d required 1 8 2",
                  natural, total, count);
      end
      drive(1'b1, 4'd1, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (natural !== 1'b0 || total !== 4'd9) begin
         n_fail++;
         $display("FAIL natural_third: nat=%b total=%0d required 0 9", natural, total);
      end
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 4'd10, 1'b0, 1'b1);
      tick();
      drive(1'b1, 4'd11, 1'b0, 1'b1);
      tick();
      n_checks++;
      if (natural !== 1'b0 || total !== 4'd0 || count !== 2'd2) begin
         n_fail++;
         $display("FAIL natural_faces: nat=%b total=%0d count=%0d required 0 0 2",
                  natural, total, count);
      end
   endtask
`endif

   task automatic test_random();
      bit v;
      bit clr;
      bit rb;
      logic [CARD_W-1:0] c;
      drive(1'b0, 4'd0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 7) == 0);
         rb  = ($urandom_range(0, 39) != 0);
         c   = CARD_W'($urandom_range(0, 15));
         drive(v, c, clr, rb);
         #1;
         n_checks++;
         if (card_ready !== exp_ready()) begin
            n_fail++;
            $display("FAIL rnd_ready%0d: ready=%b required %0b", i, card_ready, exp_ready());
         end
         tick();
         n_checks++;
         if (int'(total) != exp_total() || int'(count) != m_cnt ||
             hand_full !== (m_cnt == MAX_CARDS) || full_pulse !== m_pulse) begin
            n_fail++;
            $display("FAIL rnd_state%0d: total=%0d count=%0d full=%b pulse=%b required %0d %0d %0b %0b",
                     i, total, count, hand_full, full_pulse, exp_total(), m_cnt,
                     (m_cnt == MAX_CARDS), m_pulse);
         end
`ifdef SCOREHAND_NATURAL_EN
         n_checks++;
         if (natural !== (m_cnt == 2 && exp_total() >= MODULUS - 2)) begin
            n_fail++;
            $display("FAIL rnd_natural%0d: nat=%b required %0b", i, natural,
                     (m_cnt == 2 && exp_total() >= MODULUS - 2));
         end
`endif
      end
   endtask

   initial begin
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      test_reset();
      test_sequence();
      test_full_hold();
      test_clear_priority();
      test_zero_card();
      test_mid_reset();
`ifdef SCOREHAND_NATURAL_EN
      test_natural();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
